// File: rtl/cache_ctrl_nway.sv
// cache_ctrl_nway: N-way set-associative, write-through, no-write-allocate data
// cache between the MEM stage and the SRAM controller. Lines are 64 bits (two
// 32-bit words). Also provides a global invalidate input and saturating read
// hit/miss counters.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   address, wdata            MEM-stage byte address and store data
//   MEM_R_EN, MEM_W_EN        load / store request (load wins if both set)
//   inv                       invalidate every line (sampled in IDLE only)
//   cnt_clr                   zero both performance counters
//   rdata, ready              load data, request-complete strobe
//   sram_address, sram_wdata  SRAM controller address / store data
//   write, read               SRAM write / line-read request
//   sram_rdata, sram_ready    64-bit line from SRAM, one-cycle done pulse
//   hit_cnt, miss_cnt         saturating read hit / miss counters

// One way of the cache: a valid bit, tag and 64-bit line per set.
module cache_ctrl_nway_way #(
    parameter int SET_BITS = 6,
    parameter int TAG_W    = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inv_i,
    input  logic [SET_BITS-1:0] idx_i,
    input  logic [TAG_W-1:0]    tag_i,
    input  logic                fill_i,
    input  logic [63:0]         fill_line_i,
    input  logic                wr_i,
    input  logic                wsel_i,
    input  logic [31:0]         wword_i,
    output logic                valid_o,
    output logic                hit_o,
    output logic [63:0]         line_o
);
    localparam int SETS = 1 << SET_BITS;

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [63:0]      data_q [SETS];

    always_ff @(posedge clk) begin
        if (!rst)        valid_q <= '0;
        else if (inv_i)  valid_q <= '0;
        else if (fill_i) valid_q[idx_i] <= 1'b1;
    end

    // Tag/data carry no reset: they are meaningless while the valid bit is 0.
    always_ff @(posedge clk) begin
        if (fill_i) begin
            tag_q[idx_i]  <= tag_i;
            data_q[idx_i] <= fill_line_i;
        end else if (wr_i) begin
            if (wsel_i) data_q[idx_i][63:32] <= wword_i;
            else        data_q[idx_i][31:0]  <= wword_i;
        end
    end

    assign valid_o = valid_q[idx_i];
    assign hit_o   = valid_q[idx_i] && (tag_q[idx_i] == tag_i);
    assign line_o  = data_q[idx_i];
endmodule

module cache_ctrl_nway #(
    parameter int WAYS      = 2,
    parameter int SET_BITS  = 6,
    parameter int ADDR_BITS = 19,
    parameter int COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic               inv,
    input  logic               cnt_clr,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [31:0]        sram_address,
    output logic [31:0]        sram_wdata,
    output logic               write,
    output logic               read,
    input  logic [63:0]        sram_rdata,
    input  logic               sram_ready,
    output logic [COUNT_W-1:0] hit_cnt,
    output logic [COUNT_W-1:0] miss_cnt
);
    localparam int SETS  = 1 << SET_BITS;
    localparam int TAG_W = ADDR_BITS - 3 - SET_BITS;
    localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_e;

    state_e             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [PTR_W-1:0]   ptr_q [SETS];
    logic [COUNT_W-1:0] hit_cnt_q, miss_cnt_q;

    // Lookup uses the live address in IDLE and the latched one while a
    // miss fill or write-through is outstanding.
    logic [ADDR_BITS-1:2] lk_addr;
    logic [SET_BITS-1:0]  idx;
    logic [TAG_W-1:0]     tag;
    logic                 wsel;

    assign lk_addr = (state_q == IDLE) ? address[ADDR_BITS-1:2] : addr_q[ADDR_BITS-1:2];
    assign wsel    = lk_addr[2];
    assign idx     = lk_addr[2+SET_BITS:3];
    assign tag     = lk_addr[ADDR_BITS-1:3+SET_BITS];

    logic                  fill_en, wr_en, inv_en, hit_inc, miss_inc;
    logic [WAYS-1:0]       way_valid, way_hit;
    logic [WAYS-1:0][63:0] way_line;
    logic [PTR_W-1:0]      victim, ptr_nxt;
    logic                  hit_any;
    logic [63:0]           hit_line;
    logic [31:0]           hit_word;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_ctrl_nway_way #(
            .SET_BITS (SET_BITS),
            .TAG_W    (TAG_W)
        ) u_way (
            .clk         (clk),
            .rst         (rst),
            .inv_i       (inv_en),
            .idx_i       (idx),
            .tag_i       (tag),
            .fill_i      (fill_en && (victim == PTR_W'(w))),
            .fill_line_i (sram_rdata),
            .wr_i        (wr_en && way_hit[w]),
            .wsel_i      (wsel),
            .wword_i     (wdata_q),
            .valid_o     (way_valid[w]),
            .hit_o       (way_hit[w]),
            .line_o      (way_line[w])
        );
    end

    // At most one way matches, so an OR-reduction acts as the way mux.
    always_comb begin
        hit_line = '0;
        for (int w = 0; w < WAYS; w++)
            if (way_hit[w]) hit_line = hit_line | way_line[w];
    end

    assign hit_any  = |way_hit;
    assign hit_word = wsel ? hit_line[63:32] : hit_line[31:0];

    // Lowest-numbered invalid way wins; scanning downward lets it overwrite.
    always_comb begin
        victim = ptr_q[idx];
        for (int w = WAYS - 1; w >= 0; w--)
            if (!way_valid[w]) victim = PTR_W'(w);
    end

    assign ptr_nxt = (WAYS == 1) ? '0 : victim + PTR_W'(1);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        ready        = 1'b0;
        rdata        = '0;
        read         = 1'b0;
        write        = 1'b0;
        sram_address = '0;
        sram_wdata   = '0;
        fill_en      = 1'b0;
        wr_en        = 1'b0;
        inv_en       = 1'b0;
        hit_inc      = 1'b0;
        miss_inc     = 1'b0;
        case (state_q)
            IDLE: begin
                if (inv) begin
                    // The access, if any, is re-evaluated next cycle.
                    inv_en = 1'b1;
                end else if (MEM_R_EN) begin
                    if (hit_any) begin
                        ready   = 1'b1;
                        rdata   = hit_word;
                        hit_inc = 1'b1;
                    end else begin
                        addr_d   = address;
                        miss_inc = 1'b1;
                        state_d  = RD_MISS;
                    end
                end else if (MEM_W_EN) begin
                    addr_d  = address;
                    wdata_d = wdata;
                    state_d = WR_THRU;
                end
            end
            RD_MISS: begin
                read         = 1'b1;
                sram_address = {addr_q[31:3], 3'b000};
                if (sram_ready) begin
                    fill_en = 1'b1;
                    ready   = 1'b1;
                    rdata   = wsel ? sram_rdata[63:32] : sram_rdata[31:0];
                    state_d = IDLE;
                end
            end
            WR_THRU: begin
                write        = 1'b1;
                sram_address = addr_q;
                sram_wdata   = wdata_q;
                if (sram_ready) begin
                    wr_en   = hit_any;
                    ready   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
        end else if (fill_en) begin
            ptr_q[idx] <= ptr_nxt;
        end
    end

    // Saturating counters; clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst || cnt_clr) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_inc && !(&hit_cnt_q))   hit_cnt_q  <= hit_cnt_q + 1'b1;
            if (miss_inc && !(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + 1'b1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
endmodule

// File: tb/tb_cache_ctrl_nway.sv
module tb_cache_ctrl_nway;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address, wdata;
    logic        MEM_R_EN, MEM_W_EN, inv, cnt_clr;
    logic [31:0] rdata, sram_address, sram_wdata;
    logic        ready, write, read;
    logic [63:0] sram_rdata;
    logic        sram_ready;
    logic [3:0]  hit_cnt, miss_cnt;

    cache_ctrl_nway #(.WAYS(2), .SET_BITS(6), .ADDR_BITS(19), .COUNT_W(4)) dut (
        .clk(clk), .rst(rst), .address(address), .wdata(wdata),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .inv(inv), .cnt_clr(cnt_clr),
        .rdata(rdata), .ready(ready), .sram_address(sram_address),
        .sram_wdata(sram_wdata), .write(write), .read(read),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic wr; logic [31:0] addr; logic [31:0] wd; } req_t;
    typedef struct packed { logic is_rd; logic [31:0] data; } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   sram_hold = 0;
    logic [63:0] mem [int unsigned];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM image: line 0 is fixed; others are derived from their address.
    function automatic logic [63:0] line_rd(input logic [31:0] a);
        int unsigned k = a >> 3;
        logic [31:0] base = a & ~32'h7;
        if (mem.exists(k)) return mem[k];
        if (k == 0) return 64'h22222222_11111111;
        return {32'hB000_0004 | base, 32'hA000_0000 | base};
    endfunction

    task automatic line_wr(input logic [31:0] a, input logic [31:0] d);
        logic [63:0] l = line_rd(a);
        if (a[2]) l[63:32] = d; else l[31:0] = d;
        mem[a >> 3] = l;
    endtask

    // SRAM responder: answers each request after two cycles with a pulse.
    initial begin
        int cnt = 0;
        sram_ready = 1'b0;
        sram_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (sram_ready) begin
                sram_ready = 1'b0;
            end else if ((read || write) && !sram_hold) begin
                cnt++;
                if (cnt >= 2) begin
                    cnt = 0;
                    sram_ready = 1'b1;
                    if (read) sram_rdata = line_rd(sram_address);
                    else      line_wr(sram_address, sram_wdata);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: checks each new SRAM request and each ready against the queues.
    initial begin
        bit   seen = 0;
        req_t e;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (read || write) chk("rw_exclusive", read && write, 0);
            if ((read || write) && !seen) begin
                if (req_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req: read=%b write=%b addr=%h expected none", read, write, sram_address);
                end else begin
                    e = req_q.pop_front();
                    chk("req_write", write, e.wr);
                    chk("req_addr", sram_address, e.addr);
                    if (e.wr) chk("req_wdata", sram_wdata, e.wd);
                end
            end
            seen = read || write;
            if (ready) begin
                if (rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ready: rdata=%h expected no response", rdata);
                end else begin
                    r = rsp_q.pop_front();
                    if (r.is_rd) chk("rdata", rdata, r.data);
                end
            end
        end
    end

    task automatic wait_ready(input string name, output int n);
        n = 0;
        @(negedge clk);
        while (!ready && n < 50) begin n++; @(negedge clk); end
        if (!ready) begin
            checks++; errors++;
            $display("FAIL %s_timeout: ready=0 expected 1 within 50 cycles", name);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input bit hit,
                           input bit inv_first = 0, input bit clr = 0);
        int n;
        rsp_q.push_back('{1'b1, exp});
        if (!hit) req_q.push_back('{1'b0, {a[31:3], 3'b000}, 32'h0});
        address  = a;
        MEM_R_EN = 1'b1;
        if (inv_first) begin
            inv = 1'b1;
            @(negedge clk);
            chk("inv_ready", ready, 0);
            chk("inv_read", read, 0);
            @(posedge clk); #1;
            inv = 1'b0;
        end
        cnt_clr = clr;
        wait_ready("read", n);
        if (hit) chk("hit_same_cycle", n, 0);
        @(posedge clk); #1;
        MEM_R_EN = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        int n;
        req_q.push_back('{1'b1, a, d});
        rsp_q.push_back('{1'b0, 32'h0});
        address  = a;
        wdata    = d;
        MEM_W_EN = 1'b1;
        wait_ready("write", n);
        @(posedge clk); #1;
        MEM_W_EN = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; address = '0; wdata = '0;
        MEM_R_EN = 0; MEM_W_EN = 0; inv = 0; cnt_clr = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_read", read, 0);
        chk("rst_write", write, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_sram_addr", sram_address, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        @(posedge clk); #1;

        // Basic miss then hit on the other word of the line
        do_read(32'h000, 32'h11111111, 0);
        chk("miss_cnt_1", miss_cnt, 1);
        chk("hit_cnt_0", hit_cnt, 0);
        do_read(32'h004, 32'h22222222, 1);
        chk("hit_cnt_1", hit_cnt, 1);

        // Same index, round-robin replacement
        do_read(32'h200, 32'hA0000200, 0);
        do_read(32'h400, 32'hA0000400, 0);
        do_read(32'h200, 32'hA0000200, 1);
        do_read(32'h000, 32'h11111111, 0);
        do_read(32'h400, 32'hA0000400, 1);
        do_read(32'h200, 32'hA0000200, 0);
        chk("evict_miss_cnt", miss_cnt, 5);
        chk("evict_hit_cnt", hit_cnt, 3);

        // Write-through hit updates the line; write miss allocates nothing
        do_write(32'h004, 32'hDEADBEEF);
        do_read(32'h004, 32'hDEADBEEF, 1);
        do_write(32'h800, 32'hCAFEF00D);
        do_read(32'h800, 32'hCAFEF00D, 0);
        do_read(32'h200, 32'hA0000200, 1);
        chk("wr_hit_cnt", hit_cnt, 5);
        chk("wr_miss_cnt", miss_cnt, 6);

        // Invalidate beats a simultaneous read of a cached line
        do_read(32'h200, 32'hA0000200, 0, 1);
        chk("inv_miss_cnt", miss_cnt, 7);
        chk("inv_hit_cnt", hit_cnt, 5);

        // Saturation, then clear racing an increment
        for (int i = 0; i < 20; i++) do_read(32'h200, 32'hA0000200, 1);
        chk("sat_hit_cnt", hit_cnt, 4'hF);
        do_read(32'h200, 32'hA0000200, 1, 0, 1);
        chk("clr_hit_cnt", hit_cnt, 0);
        chk("clr_miss_cnt", miss_cnt, 0);

        do_read(32'h000, 32'h11111111, 0);
        do_read(32'h004, 32'hDEADBEEF, 1);
        chk("pre_rst_hit_cnt", hit_cnt, 1);
        chk("pre_rst_miss_cnt", miss_cnt, 1);

        // Reset while a line fill is outstanding
        sram_hold = 1'b1;
        req_q.push_back('{1'b0, 32'h1000, 32'h0});
        address  = 32'h1000;
        MEM_R_EN = 1'b1;
        repeat (3) @(negedge clk);
        chk("hold_read", read, 1);
        chk("hold_ready", ready, 0);
        @(posedge clk); #1;
        rst = 1'b0; MEM_R_EN = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_read", read, 0);
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_sram_addr", sram_address, 0);
        chk("mid_rst_hit_cnt", hit_cnt, 0);
        chk("mid_rst_miss_cnt", miss_cnt, 0);
        sram_hold = 1'b0;
        @(posedge clk); #1;
        do_read(32'h000, 32'h11111111, 0);
        chk("post_rst_miss_cnt", miss_cnt, 1);
        chk("post_rst_hit_cnt", hit_cnt, 0);

        repeat (3) @(posedge clk);
        chk("req_q_drained", req_q.size(), 0);
        chk("rsp_q_drained", rsp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_ctrl_nway.md
Name: cache_ctrl_nway

Overview:
- Parametrised N-way set-associative data cache controller between the MEM stage and the SRAM controller.
- Successor to the fixed 2-way controller. Way count, set count and counter width are parameters.
- New behaviour over the previous controller: a global invalidate input, and saturating hit/miss performance counters.
- Write-through, no-write-allocate. Line is 64 bits (two 32-bit words), matching the SRAM controller's 64-bit read.

Parameters:
- WAYS, 2, associativity; power of two, 1..4.
- SET_BITS, 6, log2 of set count (64 sets).
- ADDR_BITS, 19, significant byte-address bits; upper address bits are ignored.
- COUNT_W, 16, hit/miss counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- address  in  32  byte address from MEM stage, already offset by the caller.
- wdata  in  32  store data.
- MEM_R_EN  in  1  load request.
- MEM_W_EN  in  1  store request.
- inv  in  1  invalidate all lines.
- cnt_clr  in  1  clear both counters.
- rdata  out  32  load data.
- ready  out  1  request complete this cycle.
- sram_address  out  32  address to SRAM controller.
- sram_wdata  out  32  store data to SRAM controller.
- write  out  1  SRAM write request.
- read  out  1  SRAM read request.
- sram_rdata  in  64  line from SRAM; [31:0] is the word with address[2]=0.
- sram_ready  in  1  SRAM controller done; one-cycle pulse.
- hit_cnt  out  COUNT_W  read hits.
- miss_cnt  out  COUNT_W  read misses.

Behaviour:
- Address split:
  - word select = address[2]
  - index = address[2+SET_BITS:3]
  - tag = address[ADDR_BITS-1:3+SET_BITS]
  - address[1:0] ignored.
- Per-way storage: valid bit, tag, 64-bit data per set.
- Per-set victim pointer: log2(WAYS) bits, or 1 bit when WAYS=1 (unused).
- States: IDLE, RD_MISS, WR_THRU.
- IDLE:
  - inv=1: clear all valid bits, ready=0, no SRAM request. inv has priority over any simultaneous access; the access is evaluated next cycle as a fresh request.
  - MEM_R_EN and hit: ready=1 combinationally; rdata = selected word of the hit way; stay IDLE; hit_cnt += 1.
  - MEM_R_EN and miss: ready=0; latch address; miss_cnt += 1; go RD_MISS.
  - MEM_W_EN (with MEM_R_EN=0): ready=0; latch address and wdata; go WR_THRU.
  - Neither enable asserted: ready=0, rdata=0.
- RD_MISS:
  - read=1; sram_address = {latched[31:3],3'b000}.
  - While sram_ready=0: hold.
  - On sram_ready=1:
    - Fill victim with valid=1, tag, sram_rdata. Victim is the lowest-numbered invalid way, else the set's pointer way.
    - Pointer = victim+1 modulo WAYS.
    - ready=1 that cycle; rdata = selected word of sram_rdata (bypass).
    - Go IDLE.
- WR_THRU:
  - write=1; sram_address = latched address; sram_wdata = latched wdata.
  - On sram_ready=1:
    - If the latched address hits, update that word in the hit way.
    - A miss allocates nothing; the pointer is unchanged.
    - ready=1 that cycle; go IDLE.
- read and write are never high together; both are 0 in IDLE.
- Only IDLE samples inv; inv is ignored in RD_MISS and WR_THRU.
- Counters:
  - Saturate at all-ones; no wrap.
  - cnt_clr zeroes both counters. It has priority over an increment in the same cycle.
  - Writes are not counted.
  - A read is counted once: hit counted on its ready cycle, miss on the IDLE->RD_MISS transition.
- Multiple tag matches cannot occur; fills only target a non-matching way.
- Reset (rst=0 on a rising edge), in any state including mid-miss:
  - state=IDLE; all valid=0; pointers=0; counters=0; latches=0.
  - Next cycle: read=0, write=0, ready=0, rdata=0, sram_address=0, sram_wdata=0.
  - An outstanding sram_ready after reset is ignored in IDLE.

Test Plan:
- Reset, then read 0x000 (SRAM line 0x22222222_11111111) -> read=1, sram_address=0x000. On sram_ready: ready=1, rdata=0x11111111, miss_cnt=1. Re-read 0x004 -> same-cycle ready, rdata=0x22222222, hit_cnt=1.
- WAYS=2: read addresses 0x000, 0x200, 0x400 (same index, SET_BITS=6) -> three misses. 0x400 evicts way0 (0x000). Re-read 0x200 hits; re-read 0x000 misses.
- Store 0xDEADBEEF to cached 0x004 -> write=1, sram_wdata=0xDEADBEEF, ready on sram_ready. Following read of 0x004 hits with 0xDEADBEEF. Store to uncached 0x800 then read 0x800 -> miss.
- inv=1 in same cycle as MEM_R_EN to cached 0x000 -> ready=0, no SRAM request. Next cycle: miss, read=1, miss_cnt increments.
- COUNT_W=4: 20 read hits -> hit_cnt holds 0xF. cnt_clr together with a hit -> hit_cnt=0.
- rst=0 during RD_MISS before sram_ready -> next cycle read=0, ready=0, counters=0. Previously cached 0x000 now misses.
